note_keyboard: RTL



---
 rtl/note_keyboard.sv | 133 +++++++++++++
 1 files changed

// File: rtl/note_keyboard.sv
// Debounced 8-note keyboard with octave select; drives note frequency in Hz.
// Optional NOTE_LATCH_EN: freq holds the last note after all keys release.
module note_keyboard #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  note_btn,
    input  logic        oct_up,
    input  logic        oct_dn,
    output logic [11:0] freq,
    output logic        note_on,
    output logic        octave
);

    localparam int NIN = 10;
    localparam int UP  = 8;
    localparam int DN  = 9;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NIN-1:0] raw;
    logic [NIN-1:0] sync1;
    logic [NIN-1:0] sync2;
    logic [NIN-1:0] stable;
    logic [NIN-1:0] stable_nxt;
    logic [CNT_W-1:0] cnt [NIN];

    logic       up_rise;
    logic       dn_rise;
    logic       any_note;
    logic [2:0] sel;
    logic [11:0] tone;

    assign raw = {oct_dn, oct_up, note_btn};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    always_comb begin
        stable_nxt = stable;
        for (int i = 0; i < NIN; i++) begin
            if (sync2[i] != stable[i] && cnt[i] == CNT_MAX)
                stable_nxt[i] = ~stable[i];
        end
    end

    // Any cycle of agreement clears the run, so short glitches never flip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= '0;
            for (int i = 0; i < NIN; i++)
                cnt[i] <= '0;
        end else begin
            stable <= stable_nxt;
            for (int i = 0; i < NIN; i++) begin
                if (sync2[i] == stable[i] || cnt[i] == CNT_MAX)
                    cnt[i] <= '0;
                else
                    cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    assign up_rise = stable_nxt[UP] & ~stable[UP];
    assign dn_rise = stable_nxt[DN] & ~stable[DN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            octave <= 1'b1;
        else if (up_rise && !dn_rise)
            octave <= 1'b1;
        else if (dn_rise && !up_rise)
            octave <= 1'b0;
    end

    always_comb begin
        sel      = 3'd0;
        any_note = |stable[7:0];
        for (int i = 7; i >= 0; i--) begin
            if (stable[i])
                sel = 3'(i);
        end
    end

    always_comb begin
        tone = 12'd0;
        case ({octave, sel})
            4'b0_000: tone = 12'd131;
            4'b0_001: tone = 12'd147;
            4'b0_010: tone = 12'd165;
            4'b0_011: tone = 12'd175;
            4'b0_100: tone = 12'd196;
            4'b0_101: tone = 12'd220;
            4'b0_110: tone = 12'd247;
            4'b0_111: tone = 12'd262;
            4'b1_000: tone = 12'd262;
            4'b1_001: tone = 12'd294;
            4'b1_010: tone = 12'd330;
            4'b1_011: tone = 12'd349;
            4'b1_100: tone = 12'd392;
            4'b1_101: tone = 12'd440;
            4'b1_110: tone = 12'd494;
            4'b1_111: tone = 12'd523;
            default:  tone = 12'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq    <= 12'd0;
            note_on <= 1'b0;
        end else if (any_note) begin
            freq    <= tone;
            note_on <= 1'b1;
        end else begin
            note_on <= 1'b0;
`ifdef NOTE_LATCH_EN
            freq    <= freq;
`else
            freq    <= 12'd0;
`endif
        end
    end

endmodule
